// File: rtl/inv_seq_pkg.sv
// Shared state encoding and default timing constants for the inverter restart sequencer.
package inv_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RLY_WAIT = 3'd1,
    ST_RUN      = 3'd2,
    ST_COOL     = 3'd3,
    ST_LOCK     = 3'd4
  } seq_state_e;

  // 50 MHz clock: 10 ms relay settle, 50 ms cool-down, 1 s trip-forgiveness window
  localparam int DEF_RLY_CYC   = 500_000;
  localparam int DEF_RETRY_CYC = 2_500_000;
  localparam int DEF_MAX_TRIPS = 3;
  localparam int DEF_WIN_CYC   = 50_000_000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/inv_restart_seq_if.sv
// Sequencer command/status bundle; master drives commands, slave returns status.
interface inv_restart_seq_if;

  logic       Run_Req;
  logic       Fault;
  logic       Reset_D;
  logic       Pwm_En;
  logic       Rly_C;
  logic       Lockout;
  logic [1:0] Trip_Cnt;
  logic [2:0] State;

  modport master (
    output Run_Req, Fault, Reset_D,
    input  Pwm_En, Rly_C, Lockout, Trip_Cnt, State
  );

  modport slave (
    input  Run_Req, Fault, Reset_D,
    output Pwm_En, Rly_C, Lockout, Trip_Cnt, State
  );

endinterface

// File: rtl/inv_restart_seq_timer.sv
// seq_timer: clearable up-counter that stops at lim_i and flags terminal count.
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] lim_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == lim_i);

  // Holding at the limit keeps the counter from ever wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)              cnt_d = '0;
    else if (en_i && !tc_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/inv_restart_seq.sv
// Inverter relay/PWM restart sequencer with trip counting and lockout.
// Define INV_AUTO_RETRY_EN to enable cool-down retries and the trip-forgiveness window.
module inv_restart_seq
  import inv_seq_pkg::*;
#(
  parameter int RLY_CYC   = DEF_RLY_CYC,
  parameter int RETRY_CYC = DEF_RETRY_CYC,
  parameter int MAX_TRIPS = DEF_MAX_TRIPS,
  parameter int WIN_CYC   = DEF_WIN_CYC
) (
  input  logic       CLK_50M,
  input  logic       Rst,
  input  logic       Run_Req,
  input  logic       Fault,
  input  logic       Reset_D,
  output logic       Pwm_En,
  output logic       Rly_C,
  output logic       Lockout,
  output logic [1:0] Trip_Cnt,
  output logic [2:0] State
);

  localparam int              CNT_MAX   = max3(RLY_CYC, RETRY_CYC, WIN_CYC);
  localparam int              CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0]   RLY_LIM   = CW'(RLY_CYC - 1);
  localparam logic [CW-1:0]   RETRY_LIM = CW'(RETRY_CYC - 1);
  localparam logic [1:0]      TRIP_MAX  = 2'(MAX_TRIPS);

  seq_state_e state_q, state_d;
  logic [1:0] trip_q, trip_d, trip_base, trip_new;
  logic       rsd_q, rsd_edge, trip_ev, win_exp, tmr_tc;

  assign rsd_edge = Reset_D & ~rsd_q;
  assign trip_ev  = Fault & ((state_q == ST_RLY_WAIT) | (state_q == ST_RUN));

  // One timer serves both relay settle and cool-down; any state change restarts it.
  seq_timer #(.W(CW)) u_state_tmr (
    .clk_i (CLK_50M),
    .rst_i (Rst),
    .clr_i (state_d != state_q),
    .en_i  ((state_q == ST_RLY_WAIT) | (state_q == ST_COOL)),
    .lim_i ((state_q == ST_RLY_WAIT) ? RLY_LIM : RETRY_LIM),
    .tc_o  (tmr_tc)
  );

`ifdef INV_AUTO_RETRY_EN
  localparam logic [CW-1:0] WIN_LIM = CW'(WIN_CYC - 1);
  logic win_tc;

  seq_timer #(.W(CW)) u_win_tmr (
    .clk_i (CLK_50M),
    .rst_i (Rst),
    .clr_i ((state_q != ST_RUN) | (state_d != ST_RUN) | win_tc),
    .en_i  (state_q == ST_RUN),
    .lim_i (WIN_LIM),
    .tc_o  (win_tc)
  );

  assign win_exp = win_tc & (state_q == ST_RUN);
`else
  assign win_exp = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    trip_d    = trip_q;
    // A trip landing on window expiry counts against a freshly forgiven history.
    trip_base = win_exp ? 2'd0 : trip_q;
    trip_new  = (trip_base >= TRIP_MAX) ? TRIP_MAX : trip_base + 2'd1;
    if (rsd_edge || win_exp) trip_d = '0;
    if (trip_ev) begin
      trip_d = trip_new;
`ifdef INV_AUTO_RETRY_EN
      state_d = (trip_new == TRIP_MAX) ? ST_LOCK : ST_COOL;
`else
      state_d = ST_LOCK;
`endif
    end else begin
      case (state_q)
        ST_IDLE:     if (Run_Req && !Fault) state_d = ST_RLY_WAIT;
        ST_RLY_WAIT: if (!Run_Req) state_d = ST_IDLE;
                     else if (tmr_tc) state_d = ST_RUN;
        ST_RUN:      if (!Run_Req) state_d = ST_IDLE;
        ST_COOL:     if (!Run_Req) state_d = ST_IDLE;
                     else if (tmr_tc && !Fault) state_d = ST_RUN;
        ST_LOCK:     if (rsd_edge) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      trip_q  <= '0;
      rsd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      trip_q  <= trip_d;
      rsd_q   <= Reset_D;
    end
  end

  // Fault gates PWM combinationally so cut-off does not wait for a clock edge.
  assign Pwm_En   = (state_q == ST_RUN) & ~Fault;
  assign Rly_C    = (state_q == ST_RLY_WAIT) | (state_q == ST_RUN) | (state_q == ST_COOL);
  assign Lockout  = (state_q == ST_LOCK);
  assign Trip_Cnt = trip_q;
  assign State    = state_q;

endmodule

// File: tb/tb_inv_restart_seq.sv
// Randomized + directed bench for inv_restart_seq against a time-in-state reference model.
module tb_inv_restart_seq;

  localparam int RLY   = 4;
  localparam int RETRY = 8;
  localparam int MAXT  = 3;
  localparam int WIN   = 32;
`ifdef INV_AUTO_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  localparam int S_IDLE = 0, S_RW = 1, S_RUN = 2, S_COOL = 3, S_LOCK = 4;

  logic CLK_50M = 1'b0;
  logic Rst;
  inv_restart_seq_if bus ();

  inv_restart_seq #(
    .RLY_CYC(RLY), .RETRY_CYC(RETRY), .MAX_TRIPS(MAXT), .WIN_CYC(WIN)
  ) dut (
    .CLK_50M  (CLK_50M),
    .Rst      (Rst),
    .Run_Req  (bus.Run_Req),
    .Fault    (bus.Fault),
    .Reset_D  (bus.Reset_D),
    .Pwm_En   (bus.Pwm_En),
    .Rly_C    (bus.Rly_C),
    .Lockout  (bus.Lockout),
    .Trip_Cnt (bus.Trip_Cnt),
    .State    (bus.State)
  );

  always #10 CLK_50M = ~CLK_50M;

  int n_chk = 0;
  int n_fail = 0;
  int m_st, m_tim, m_win, m_trips;
  bit m_rdp;
  logic pwm_seen;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    m_st = S_IDLE; m_tim = 0; m_win = 0; m_trips = 0; m_rdp = 1'b0;
  endtask

  // m_tim = cycles already spent in the current state, m_win = RUN cycles in the current window.
  task automatic mdl_step(input bit rr, input bit f, input bit rd);
    bit edge_s, expire, trip;
    int nst;
    edge_s = rd && !m_rdp;
    m_rdp  = rd;
    expire = RETRY_EN && (m_st == S_RUN) && (m_win + 1 >= WIN);
    trip   = f && (m_st == S_RW || m_st == S_RUN);
    nst    = m_st;
    if (trip) begin
      m_trips = (expire ? 0 : m_trips) + 1;
      if (m_trips > MAXT) m_trips = MAXT;
      nst = (!RETRY_EN || m_trips == MAXT) ? S_LOCK : S_COOL;
    end else begin
      if (edge_s || expire) m_trips = 0;
      case (m_st)
        S_IDLE: if (rr && !f) nst = S_RW;
        S_RW:   if (!rr) nst = S_IDLE; else if (m_tim + 1 >= RLY) nst = S_RUN;
        S_RUN:  if (!rr) nst = S_IDLE;
        S_COOL: if (!rr) nst = S_IDLE; else if (m_tim + 1 >= RETRY && !f) nst = S_RUN;
        S_LOCK: if (edge_s) nst = S_IDLE;
        default: nst = S_IDLE;
      endcase
    end
    m_tim = (nst != m_st) ? 0 : m_tim + 1;
    m_win = (nst == S_RUN && m_st == S_RUN && !expire) ? m_win + 1 : 0;
    m_st  = nst;
  endtask

  // Apply inputs at negedge, compare against model, then advance model past the posedge.
  task automatic drive(input bit rst, input bit rr, input bit f, input bit rd);
    @(negedge CLK_50M);
    Rst = rst; bus.Run_Req = rr; bus.Fault = f; bus.Reset_D = rd;
    #1;
    chk("state", int'(bus.State), m_st);
    chk("pwm_en", int'(bus.Pwm_En), (m_st == S_RUN && !f) ? 1 : 0);
    chk("rly_c", int'(bus.Rly_C), (m_st == S_RW || m_st == S_RUN || m_st == S_COOL) ? 1 : 0);
    chk("lockout", int'(bus.Lockout), (m_st == S_LOCK) ? 1 : 0);
    chk("trip_cnt", int'(bus.Trip_Cnt), m_trips);
    pwm_seen = bus.Pwm_En;
    @(posedge CLK_50M);
    #1;
    if (rst) mdl_reset();
    else     mdl_step(rr, f, rd);
  endtask

  initial begin
    bit rr;
    int guard;
    int frate;
    Rst = 1'b1; bus.Run_Req = 1'b0; bus.Fault = 1'b0; bus.Reset_D = 1'b0;
    repeat (2) @(posedge CLK_50M);
    #1;
    mdl_reset();
    chk("rst_state", int'(bus.State), 0);
    chk("rst_pwm", int'(bus.Pwm_En), 0);
    chk("rst_rly", int'(bus.Rly_C), 0);
    chk("rst_lock", int'(bus.Lockout), 0);
    chk("rst_trips", int'(bus.Trip_Cnt), 0);

    // Fault held in IDLE blocks the start
    drive(0, 1, 1, 0);
    chk("idle_fault_blocks", int'(bus.State), 0);

    // Start-up: relay closes one cycle after the request, PWM four cycles later
    drive(0, 1, 0, 0);
    chk("start_rly", int'(bus.Rly_C), 1);
    chk("start_state", int'(bus.State), 1);
    repeat (3) drive(0, 1, 0, 0);
    chk("rly_wait_pwm", int'(bus.Pwm_En), 0);
    drive(0, 1, 0, 0);
    chk("pwm_on", int'(bus.Pwm_En), 1);
    chk("run_state", int'(bus.State), 2);

`ifdef INV_AUTO_RETRY_EN
    drive(0, 1, 1, 0);
    chk("trip_pwm_cut", int'(pwm_seen), 0);
    chk("trip_cool", int'(bus.State), 3);
    chk("trip_cnt1", int'(bus.Trip_Cnt), 1);
    repeat (7) drive(0, 1, 0, 0);
    chk("cool_hold", int'(bus.State), 3);
    drive(0, 1, 0, 0);
    chk("cool_rerun", int'(bus.State), 2);
    repeat (31) drive(0, 1, 0, 0);
    chk("win_pre", int'(bus.Trip_Cnt), 1);
    drive(0, 1, 0, 0);
    chk("win_clear", int'(bus.Trip_Cnt), 0);
    drive(0, 1, 1, 0);
    repeat (8) drive(0, 1, 0, 0);
    repeat (31) drive(0, 1, 0, 0);
    chk("win_pre2", int'(bus.Trip_Cnt), 1);
    drive(0, 1, 1, 0);
    chk("trip_at_expiry", int'(bus.Trip_Cnt), 1);
    repeat (8) drive(0, 1, 0, 0);
    drive(0, 1, 1, 0);
    chk("trip_cnt2", int'(bus.Trip_Cnt), 2);
    repeat (8) drive(0, 1, 0, 0);
    drive(0, 1, 1, 0);
    chk("lock_trips", int'(bus.Trip_Cnt), 3);
`else
    drive(0, 1, 1, 0);
    chk("trip_pwm_cut", int'(pwm_seen), 0);
    chk("lock_trips", int'(bus.Trip_Cnt), 1);
`endif
    chk("lock_state", int'(bus.State), 4);
    chk("lock_flag", int'(bus.Lockout), 1);
    chk("lock_rly", int'(bus.Rly_C), 0);

    repeat (3) drive(0, 1, 1, 0);
    chk("lock_ignores_inputs", int'(bus.State), 4);
    drive(0, 1, 0, 1);
    chk("lock_exit", int'(bus.State), 0);
    chk("lock_exit_trips", int'(bus.Trip_Cnt), 0);

    // Trip and Reset_D edge in the same cycle: the trip is kept, the edge is lost
    repeat (5) drive(0, 1, 0, 0);
    chk("run_again", int'(bus.State), 2);
    drive(0, 1, 1, 1);
    chk("trip_beats_edge", int'(bus.Trip_Cnt), 1);
    drive(0, 1, 0, 1);
    chk("edge_discarded", int'(bus.State), RETRY_EN ? 3 : 4);
    chk("edge_discarded_cnt", int'(bus.Trip_Cnt), 1);

    // Reach LOCK, then synchronous reset clears everything
    guard = 0;
    while (bus.Lockout !== 1'b1 && guard < 200) begin
      drive(0, 1, (bus.State == 3'd2), 0);
      guard++;
    end
    chk("reach_lock", int'(bus.Lockout), 1);
    drive(1, 1, 1, 0);
    chk("rst_lock_state", int'(bus.State), 0);
    chk("rst_lock_pwm", int'(bus.Pwm_En), 0);
    chk("rst_lock_rly", int'(bus.Rly_C), 0);
    chk("rst_lock_flag", int'(bus.Lockout), 0);
    chk("rst_lock_trips", int'(bus.Trip_Cnt), 0);

    // Randomized phase, alternating quiet and noisy fault segments
    rr = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      frate = ((i / 500) % 2 == 1) ? 8 : 50;
      if ($urandom_range(0, 99) < 3) rr = !rr;
      drive(($urandom_range(0, 499) == 0), rr,
            ($urandom_range(0, 999) < frate), ($urandom_range(0, 99) < 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
